// File: rtl/ssd_bcd_display.sv
// 4-digit common-anode seven-segment back-end with a sequential double-dabble
// binary-to-BCD converter. Optional build macro: SSD_LEADING_ZERO_BLANK_EN.
module ssd_bcd_display #(
    parameter int IN_WIDTH     = 13,
    parameter int REFRESH_BITS = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] value,
    input  logic                load,
    output logic                busy,
    output logic [3:0]          anode,
    output logic [6:0]          cathode
);

    localparam int         BIN_W     = 13;
    localparam int         BCD_W     = 16;
    localparam logic [3:0] LAST_ITER = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [BIN_W-1:0]        bin_q;
    logic [BIN_W-1:0]        bin_d;
    logic [BCD_W-1:0]        bcd_q;
    logic [BCD_W-1:0]        bcd_d;
    logic [3:0]              iter_q;
    logic [3:0]              iter_d;
    logic [BCD_W-1:0]        disp_q;
    logic [BCD_W-1:0]        disp_d;
    logic [BIN_W-1:0]        value_ext;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W+BIN_W-1:0]  shifted;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic                    blank;
    logic [3:0]              anode_d;
    logic [6:0]              cathode_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        value_ext                = '0;
        value_ext[IN_WIDTH-1:0]  = value;
    end

    // Double-dabble correction: any nibble >= 5 would overflow past 9 on the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        disp_d  = disp_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = value_ext;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (load) begin
                    bin_d  = value_ext;
                    bcd_d  = '0;
                    iter_d = '0;
                end else begin
                    bcd_d  = shifted[BCD_W+BIN_W-1:BIN_W];
                    bin_d  = shifted[BIN_W-1:0];
                    iter_d = iter_q + 4'd1;
                    if (iter_q == LAST_ITER) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                disp_d  = bcd_q;
                state_d = IDLE;
                // A strobe landing on the commit cycle starts the next conversion.
                if (load) begin
                    bin_d   = value_ext;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
        end
    end

    assign busy = (state_q != IDLE);

    assign sel = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        digit   = disp_q[3:0];
        anode_d = 4'b1110;
        unique case (sel)
            2'd0: begin
                digit   = disp_q[3:0];
                anode_d = 4'b1110;
            end
            2'd1: begin
                digit   = disp_q[7:4];
                anode_d = 4'b1101;
            end
            2'd2: begin
                digit   = disp_q[11:8];
                anode_d = 4'b1011;
            end
            default: begin
                digit   = disp_q[15:12];
                anode_d = 4'b0111;
            end
        endcase
    end

    // Blanking looks only at committed digits so it never flickers mid-conversion.
    always_comb begin
        blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        unique case (sel)
            2'd3:    blank = (disp_q[15:12] == 4'd0);
            2'd2:    blank = (disp_q[15:8] == 8'd0);
            2'd1:    blank = (disp_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        cathode_d = blank ? 7'b1111111 : seg_decode(digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            anode     <= 4'b1111;
            cathode   <= 7'b1111111;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            anode     <= anode_d;
            cathode   <= cathode_d;
        end
    end

endmodule
